// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin grant arbiter.
// Holds the FSM state encoding and the default NREQ/MAX_HOLD sizes.
package rr_arb_pkg;

  localparam int STATE_W      = 2;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set req bit scanning from ptr upward, wrapping.
// Ports: req (requests), ptr (start index) -> found (any pick), idx (picked index).
module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = ID_W'((int'(ptr) + i) % NREQ);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant and one TURN cycle per handoff.
// Ports: clock, reset_n (async low), req -> gnt, gnt_valid, gnt_id, preempt.
// Define ARB_TIMEOUT_EN to preempt an owner held MAX_HOLD cycles while others wait.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int NREQ     = DEF_NREQ,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int ID_W     = $clog2(NREQ)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic            preempt
);

  if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 2) begin : g_bad_cfg
    $error("rr_grant_arbiter: unsupported NREQ/MAX_HOLD");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [ID_W-1:0] r_gnt_id;
  logic [ID_W-1:0] w_gnt_id_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [ID_W-1:0] w_ptr_inc;
  logic            r_gnt_valid;
  logic            r_preempt;
  logic            w_preempt_nxt;
  logic            w_found;
  logic [ID_W-1:0] w_pick;
  logic            w_owner_req;
  logic            w_timeout;

  rr_priority_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_pick)
  );

  assign w_owner_req = req[r_gnt_id];
  assign w_ptr_inc   = (r_gnt_id == ID_W'(NREQ - 1)) ?
                       '0 : r_gnt_id + ID_W'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD);

  logic [HC_W-1:0] r_hold_cnt;
  logic            w_others;

  assign w_others  = |(req & ~r_gnt);
  assign w_timeout = (r_hold_cnt == HC_W'(MAX_HOLD - 1)) && w_others;

  // Counts cycles of the current tenure; cleared on every new grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt <= '0;
    end else if (r_state == GRANT && w_state_nxt == GRANT) begin
      if (r_hold_cnt != HC_W'(MAX_HOLD - 1))
        r_hold_cnt <= r_hold_cnt + HC_W'(1);
    end else begin
      r_hold_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_ptr_nxt     = r_ptr;
    w_preempt_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt  = GRANT;
          w_gnt_nxt    = NREQ'(1) << w_pick;
          w_gnt_id_nxt = w_pick;
        end
      end
      GRANT: begin
        // Owner release wins over timeout; preempt only pulses if owner still asks.
        if (!w_owner_req || w_timeout) begin
          w_state_nxt   = TURN;
          w_gnt_nxt     = '0;
          w_gnt_id_nxt  = '0;
          w_ptr_nxt     = w_ptr_inc;
          w_preempt_nxt = w_owner_req;
        end
      end
      TURN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_ptr       <= '0;
      r_preempt   <= 1'b0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= |w_gnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_preempt   <= w_preempt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (NREQ=4, MAX_HOLD=8).
// Timeout steps follow ARB_TIMEOUT_EN; the default build checks the held grant.
module tb_rr_grant_arbiter;

  logic       clock;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;

  int passed;
  int total;

  rr_grant_arbiter #(
    .NREQ     (4),
    .MAX_HOLD (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .preempt   (preempt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg,
                         input logic [1:0] eid, input logic ep);
    chk({tag, ".gnt"},   32'(gnt),       32'(eg));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(|eg));
    chk({tag, ".id"},    32'(gnt_id),    32'(eid));
    chk({tag, ".pre"},   32'(preempt),   32'(ep));
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    reset_n = 1'b0;
    req     = 4'b0000;
    #12;
    chk_out("rst", 4'b0000, 2'd0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_out("idle0", 4'b0000, 2'd0, 1'b0);

    // async reset mid-grant, no clock edge between assert and check
    req = 4'b0010;
    tick();
    chk_out("pre_rst", 4'b0010, 2'd1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_rst", 4'b0000, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    reset_n = 1'b1;
    tick();

    // rotation 0,1,2,3,0 with req=1111, each owner drops for one cycle
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("rot%0d_a", k), 4'b0001 << (k % 4),
              2'(k % 4), 1'b0);
      tick();
      chk_out($sformatf("rot%0d_b", k), 4'b0001 << (k % 4),
              2'(k % 4), 1'b0);
      req = 4'b1111 & ~(4'b0001 << (k % 4));
      tick();
      chk_out($sformatf("rot%0d_turn", k), 4'b0000, 2'd0, 1'b0);
      req = (k == 4) ? 4'b0000 : 4'b1111;
      tick();
      chk_out($sformatf("rot%0d_idle", k), 4'b0000, 2'd0, 1'b0);
    end
    // ptr is now 1

    // single requester 2
    req = 4'b0100;
    tick();
    chk_out("single", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    chk_out("single_turn", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_out("single_idle", 4'b0000, 2'd0, 1'b0);
    // ptr is now 3

    // wrap: ptr=3 picks 3, then ptr=0 picks 0
    req = 4'b1001;
    tick();
    chk_out("wrap_a", 4'b1000, 2'd3, 1'b0);
    req = 4'b0001;
    tick();
    chk_out("wrap_turn", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    tick();
    chk_out("wrap_idle", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_out("wrap_b", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    tick();
    // ptr is now 1

    // simultaneous: owner 1 drops as req[2] rises
    req = 4'b0010;
    tick();
    chk_out("sim_own", 4'b0010, 2'd1, 1'b0);
    req = 4'b0100;
    tick();
    chk_out("sim_turn", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_out("sim_idle", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_out("sim_new", 4'b0100, 2'd2, 1'b0);
    req = 4'b0111;
    tick();
    chk_out("sim_ignore", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    tick();
    // ptr is now 3

    req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_out($sformatf("to_hold%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    tick();
    chk_out("to_preempt", 4'b0000, 2'd0, 1'b1);
    tick();
    chk_out("to_idle", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_out("to_next", 4'b0010, 2'd1, 1'b0);
    req = 4'b0001;
    tick();
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_out($sformatf("to_alone%0d", c), 4'b0001, 2'd0, 1'b0);
    end
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_out($sformatf("hold%0d", c), 4'b0001, 2'd0, 1'b0);
    end
`endif
    req = 4'b0000;
    tick();
    tick();
    chk_out("end_idle", 4'b0000, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
